wildcard_match_table: RTL
=========================

# wildcard_match_table

Parametrised, programmable wildcard pattern classifier: the run-time-configurable, pipelined successor to our fixed casex decoders. Each incoming DATA_W-bit word is compared against ENTRIES programmable (value, care-mask, code) entries. The lowest-index matching entry's code is returned through a registered valid/ready output stage, with DEFAULT_CODE returned on a miss. It sits between a packet/field extractor and downstream dispatch logic.

## Interface
- DATA_W, 4, lookup word width (≥1)
- ENTRIES, 4, number of table entries (≥2)
- CODE_W, 2, result code width
- IDX_W, $clog2(ENTRIES), entry index width (derived, not overridden)
- DEFAULT_CODE, 0, code returned on miss and at reset
- CNT_W, 16, width of miss counter
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- cfg_we  input  1  write one table entry this cycle
- cfg_idx  input  IDX_W  entry to write
- cfg_en  input  1  entry enable bit to store
- cfg_value  input  DATA_W  pattern value
- cfg_mask  input  DATA_W  care mask (1 = compare bit, 0 = wildcard)
- cfg_code  input  CODE_W  code returned on match
- in_valid  input  1  lookup request valid
- in_ready  output  1  lookup accepted when in_valid & in_ready
- in_data  input  DATA_W  word to classify
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_hit  output  1  some enabled entry matched
- out_idx  output  IDX_W  index of winning entry (0 on miss)
- out_code  output  CODE_W  winning code, DEFAULT_CODE on miss
- miss_cnt  output  CNT_W  saturating count of accepted misses

## Operation
- Entry i matches when en[i] and ((in_data ^ value[i]) & mask[i]) == 0. An all-zero mask matches any word.
- Priority: lowest matching index wins. Later entries that also match are ignored.
- cfg_idx ≥ ENTRIES: write is ignored.
- Config writes are allowed at any time, including while lookups are in flight.
- Results already registered are never altered by a later config write.
- Output register loads on accept (in_valid & in_ready).
- in_ready = !out_valid | out_ready. Supports full throughput (one result per cycle) while out_ready is high.
- While out_valid & !out_ready, all output fields hold stable.
- miss_cnt increments on each accepted miss and saturates at 2^CNT_W−1.
- Reset values:
  - all entries: en=0, value=0, mask=0, code=DEFAULT_CODE
  - out_valid=0, out_hit=0, out_idx=0, out_code=DEFAULT_CODE
  - miss_cnt=0
  - in_ready=1 (combinational from out_valid)

## Timing
- Lookup latency: 1 cycle. A word accepted at edge N has its result visible after edge N with out_valid=1.
- Config write at edge N takes effect for lookups accepted at edge N+1 or later.
  - A lookup accepted on the same edge as a write uses the pre-write table contents.
- Write and lookup to the same entry on the same edge: the lookup sees the old entry.
- No state machine. The only state is the table, the one-deep output register and the counter.
- rst_n low mid-transfer: the pending result is dropped (out_valid=0 after that edge) and the table is cleared. Reset overrides a simultaneous cfg_we.
- Simulation: X/Z on masked-off in_data bits must not affect the result. X on cared bits is a bench error; the bench does not drive it.

## Structure
- Package wildcard_match_pkg holds:
  - entry struct {en, value, mask, code}
  - the default parameter constants
  - a localparam for miss-counter saturation
- Sub-module wildcard_match_entry: combinational single-entry comparator producing match[i], instantiated ENTRIES times.
- The top level holds:
  - the table registers
  - a fixed-priority first-one selector over match[]
  - the output register and miss counter

## Test plan
- Legacy-equivalence table, defaults, out_ready=1. Program:
  - entry0: value 1000, mask 1011, code 01
  - entry1: value 0100, mask 1101, code 10
  - Stream 1000, 1100, 0100, 0110, 1111 → codes 01, 01, 10, 10, 00.
  - Hit/idx for the five words: 1/0, 1/0, 1/1, 1/1, 0/0.
  - miss_cnt=1 at the end.
- Priority: additionally program entry3 with mask 0000, code 11.
  - 1000 → idx 0, code 01.
  - 0011 → idx 3, code 11, hit=1.
- Backpressure: hold out_ready=0 for 3 cycles after a result.
  - in_ready=0 and all out_* fields stable during the hold.
  - Release → next word accepted on the following edge, no loss or duplication.
- Same-edge write: rewrite entry0 to code 11 on the edge that accepts 1000 → that result is 01; the next 1000 returns 11.
- Saturation: with CNT_W=2, 5 accepted misses → miss_cnt 1, 2, 3, 3, 3.
- Reset mid-operation: with out_valid=1, assert rst_n=0 for one edge.
  - Outputs return to reset values.
  - 1000 afterwards → miss, DEFAULT_CODE (table cleared).

Source files
------------

// File: rtl/wildcard_match_pkg.sv
// rtl/wildcard_match_pkg.sv - shared types and default constants for the wildcard match table
// Contents: default parameter values, default-width entry struct, miss-counter saturation value.
package wildcard_match_pkg;

  localparam int DATA_W_DEF       = 4;
  localparam int ENTRIES_DEF      = 4;
  localparam int CODE_W_DEF       = 2;
  localparam int DEFAULT_CODE_DEF = 0;
  localparam int CNT_W_DEF        = 16;

  // Saturation value of the miss counter at its default width.
  localparam logic [CNT_W_DEF-1:0] MISS_CNT_SAT_DEF = {CNT_W_DEF{1'b1}};

  // One table entry at the default widths; the top declares the same shape at its own widths.
  typedef struct packed {
    logic                  en;
    logic [DATA_W_DEF-1:0] value;
    logic [DATA_W_DEF-1:0] mask;
    logic [CODE_W_DEF-1:0] code;
  } wm_entry_t;

endpackage

// File: rtl/wildcard_match_table_if.sv
// rtl/wildcard_match_table_if.sv - config, lookup and result bundle for wildcard_match_table
// Signals: cfg_* (entry write), in_* (lookup request handshake), out_* (result handshake), miss_cnt.
// Modports: slave = table side, master = user side.
interface wildcard_match_table_if #(
  parameter int DATA_W = 4,
  parameter int IDX_W  = 2,
  parameter int CODE_W = 2,
  parameter int CNT_W  = 16
);
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic              cfg_en;
  logic [DATA_W-1:0] cfg_value;
  logic [DATA_W-1:0] cfg_mask;
  logic [CODE_W-1:0] cfg_code;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  logic              out_valid;
  logic              out_ready;
  logic              out_hit;
  logic [IDX_W-1:0]  out_idx;
  logic [CODE_W-1:0] out_code;
  logic [CNT_W-1:0]  miss_cnt;

  modport slave (
    input  cfg_we, cfg_idx, cfg_en, cfg_value, cfg_mask, cfg_code,
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_hit, out_idx, out_code, miss_cnt
  );

  modport master (
    output cfg_we, cfg_idx, cfg_en, cfg_value, cfg_mask, cfg_code,
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_hit, out_idx, out_code, miss_cnt
  );
endinterface

// File: rtl/wildcard_match_entry.sv
// rtl/wildcard_match_entry.sv - combinational comparator for one table entry
// Ports: i_en, i_value, i_mask (stored entry), i_data (lookup word), o_match.
module wildcard_match_entry #(
  parameter int DATA_W = 4
) (
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_value,
  input  logic [DATA_W-1:0] i_mask,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_match
);
  // Masking after the XOR forces wildcard bits to 0 even when i_data carries X there.
  assign o_match = i_en & ~|((i_data ^ i_value) & i_mask);
endmodule

// File: rtl/wildcard_match_table.sv
// rtl/wildcard_match_table.sv - programmable priority wildcard classifier with registered result
// Ports: clk, rst_n (sync, active-low), bus (wildcard_match_table_if.slave: cfg writes,
// in_valid/in_ready/in_data lookup, out_valid/out_ready/out_hit/out_idx/out_code result, miss_cnt).
module wildcard_match_table
  import wildcard_match_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ENTRIES      = ENTRIES_DEF,
  parameter int CODE_W       = CODE_W_DEF,
  parameter int DEFAULT_CODE = DEFAULT_CODE_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  wildcard_match_table_if.slave  bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CODE_W-1:0] DEF_CODE = CODE_W'(DEFAULT_CODE);
  localparam logic [CNT_W-1:0]  CNT_SAT  = {CNT_W{1'b1}};

  typedef struct packed {
    logic              en;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] mask;
    logic [CODE_W-1:0] code;
  } entry_t;

  entry_t            r_tab [ENTRIES];
  logic              r_out_valid;
  logic              r_out_hit;
  logic [IDX_W-1:0]  r_out_idx;
  logic [CODE_W-1:0] r_out_code;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [ENTRIES-1:0] w_match;
  logic               w_hit;
  logic [IDX_W-1:0]   w_idx;
  logic               w_accept;

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    wildcard_match_entry #(.DATA_W(DATA_W)) u_entry (
      .i_en    (r_tab[g].en),
      .i_value (r_tab[g].value),
      .i_mask  (r_tab[g].mask),
      .i_data  (bus.in_data),
      .o_match (w_match[g])
    );
  end

  // Scan from the top down so the lowest matching index is the last one written.
  always_comb begin
    w_hit = 1'b0;
    w_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit = 1'b1;
        w_idx = IDX_W'(i);
      end
    end
  end

  assign bus.in_ready = !r_out_valid || bus.out_ready;
  assign w_accept     = bus.in_valid && bus.in_ready;

  // The comparators read r_tab, so a lookup on the same edge as a write sees the old entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_tab[i] <= '{en: 1'b0, value: '0, mask: '0, code: DEF_CODE};
      end
    end else if (bus.cfg_we && (int'(bus.cfg_idx) < ENTRIES)) begin
      r_tab[bus.cfg_idx] <= '{en: bus.cfg_en, value: bus.cfg_value,
                              mask: bus.cfg_mask, code: bus.cfg_code};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_hit   <= 1'b0;
      r_out_idx   <= '0;
      r_out_code  <= DEF_CODE;
      r_miss_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_out_hit   <= w_hit;
        r_out_idx   <= w_idx;
        r_out_code  <= w_hit ? r_tab[w_idx].code : DEF_CODE;
        if (!w_hit && (r_miss_cnt != CNT_SAT)) begin
          r_miss_cnt <= r_miss_cnt + 1'b1;
        end
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_hit   = r_out_hit;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_code  = r_out_code;
  assign bus.miss_cnt  = r_miss_cnt;
endmodule
